// File: rtl/axi4_sram_pkg.sv
// Shared types and constants for the axi4_sram AXI4-to-SRAM bridge.
package axi4_sram_pkg;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, READ} state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_WORD   = 3'd2;

  // Any non-32-bit beat or non-INCR burst type is unsupported by this bridge.
  function automatic logic bad_attr(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || (burst inside {BURST_FIXED, BURST_WRAP}) ||
           (burst != BURST_INCR);
  endfunction

endpackage

// File: rtl/axi4_sram_if.sv
// AXI4 bus bundle (32-bit data) with master/slave modports.
interface axi4_sram_if #(parameter int IWIDTH = 5);

  logic [IWIDTH-1:0] awid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid, awready;

  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast, wvalid, wready;

  logic [IWIDTH-1:0] bid;
  logic [1:0]        bresp;
  logic              bvalid, bready;

  logic [IWIDTH-1:0] arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid, arready;

  logic [IWIDTH-1:0] rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/axi4_sram_rbuf.sv
// Two-entry {data,last} skid FIFO holding SRAM read data for the R channel.
module axi4_sram_rbuf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        push_last,
  input  logic        pop,
  output logic [31:0] head_data,
  output logic        head_last,
  output logic [1:0]  count,
  output logic        empty,
  output logic        full
);

  logic [31:0] data0, data1;
  logic        last0, last1;

  always_ff @(posedge clk) begin
    if (!rst_n) count <= 2'd0;
    else        count <= count + 2'(push) - 2'(pop);
  end

  // NOTE: payload slots carry no reset; count alone decides whether they hold anything.
  always_ff @(posedge clk) begin
    case ({push, pop})
      2'b10: begin
        if (count == 2'd0) begin data0 <= push_data; last0 <= push_last; end
        else               begin data1 <= push_data; last1 <= push_last; end
      end
      2'b01: begin data0 <= data1; last0 <= last1; end
      2'b11: begin
        if (count == 2'd1) begin
          data0 <= push_data; last0 <= push_last;
        end else begin
          data0 <= data1;     last0 <= last1;
          data1 <= push_data; last1 <= push_last;
        end
      end
      default: ;
    endcase
  end

  assign head_data = data0;
  assign head_last = last0;
  assign empty     = (count == 2'd0);
  assign full      = (count == 2'd2);

endmodule

// File: rtl/axi4_sram.sv
// AXI4 slave front-end serialising INCR bursts onto an external 4096x32 SRAM.
// Define AXI4_SRAM_CHECK_EN to flag non-32-bit / non-INCR bursts with SLVERR.
module axi4_sram
  import axi4_sram_pkg::*;
#(
  parameter int AWIDTH = 12,
  parameter int IWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  axi4_sram_if.slave        s,
  output logic              o_we,
  output logic [AWIDTH-1:0] o_waddr,
  output logic [31:0]       o_wdata,
  output logic [AWIDTH-1:0] o_raddr,
  input  logic [31:0]       i_rdata
);

  state_e            state, state_nx;
  logic [AWIDTH-1:0] addr;
  logic [8:0]        beats_left;
  logic [IWIDTH-1:0] id_q;
  logic              err_q, pend, pend_last;
  logic              aw_hs, ar_hs, w_hs, b_hs, r_pop, issue;
  logic              attr_err_aw, attr_err_ar;
  logic [1:0]        rb_count, occ;
  logic              rb_empty, rb_full, rb_head_last;
  logic [31:0]       rb_head_data;

`ifdef AXI4_SRAM_CHECK_EN
  assign attr_err_aw = bad_attr(s.awsize, s.awburst);
  assign attr_err_ar = bad_attr(s.arsize, s.arburst);
`else
  assign attr_err_aw = 1'b0;
  assign attr_err_ar = 1'b0;
`endif

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (aw_hs) state_nx = WDATA; else if (ar_hs) state_nx = READ;
      WDATA:   if (w_hs && beats_left == 9'd1) state_nx = WRESP;
      WRESP:   if (b_hs) state_nx = IDLE;
      READ:    if (r_pop && rb_head_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
  always_comb begin
    s.awready = 1'b0;
    s.arready = 1'b0;
    s.wready  = 1'b0;
    s.bvalid  = 1'b0;
    case (state)
      IDLE: begin
        s.awready = rst_n;
        s.arready = rst_n & ~s.awvalid;   // write wins a same-cycle tie
      end
      WDATA:   s.wready = rst_n;
      WRESP:   s.bvalid = rst_n;
      default: ;
    endcase
  end

  assign aw_hs = s.awvalid & s.awready;
  assign ar_hs = s.arvalid & s.arready;
  assign w_hs  = s.wvalid & s.wready;
  assign b_hs  = s.bvalid & s.bready;
  assign r_pop = s.rvalid & s.rready;

  // Count in-flight SRAM reads against buffer room so the skid buffer never overflows.
  assign occ   = rb_count + 2'(pend);
  assign issue = (state == READ) && (beats_left != 9'd0) && ((occ != 2'd2) || r_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr       <= '0;
      beats_left <= '0;
      id_q       <= '0;
      err_q      <= 1'b0;
      pend       <= 1'b0;
      pend_last  <= 1'b0;
    end else begin
      pend      <= issue;
      pend_last <= issue && (beats_left == 9'd1);
      if (aw_hs) begin
        addr       <= s.awaddr[AWIDTH+1:2];
        beats_left <= {1'b0, s.awlen} + 9'd1;
        id_q       <= s.awid;
        err_q      <= attr_err_aw;
      end else if (ar_hs) begin
        addr       <= s.araddr[AWIDTH+1:2];
        beats_left <= {1'b0, s.arlen} + 9'd1;
        id_q       <= s.arid;
        err_q      <= attr_err_ar;
      end else if (w_hs || issue) begin
        addr       <= addr + 1'b1;
        beats_left <= beats_left - 9'd1;
      end
    end
  end

  axi4_sram_rbuf u_rbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend),
    .push_data (err_q ? 32'd0 : i_rdata),
    .push_last (pend_last),
    .pop       (r_pop),
    .head_data (rb_head_data),
    .head_last (rb_head_last),
    .count     (rb_count),
    .empty     (rb_empty),
    .full      (rb_full)
  );

  assign s.rvalid = ~rb_empty;
  assign s.rdata  = rb_head_data;
  assign s.rlast  = rb_head_last & ~rb_empty;
  assign s.rid    = id_q;
  assign s.rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
  assign s.bid    = id_q;
  assign s.bresp  = err_q ? RESP_SLVERR : RESP_OKAY;

  assign o_we    = w_hs & ~err_q;
  assign o_waddr = addr;
  assign o_wdata = s.wdata;
  assign o_raddr = addr;

  logic unused_ok;
  assign unused_ok = ^{s.awaddr, s.araddr, s.wstrb, s.wlast, s.awsize, s.awburst,
                       s.arsize, s.arburst, rb_full};

endmodule

// File: tb/tb_axi4_sram.sv
// Scoreboard bench for axi4_sram: stimulus pushes expectations, a negedge monitor checks them.
module tb_axi4_sram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_we;
  logic [11:0] o_waddr, o_raddr;
  logic [31:0] o_wdata, i_rdata;

  always #5 clk = ~clk;

  axi4_sram_if #(.IWIDTH(5)) bus ();

  axi4_sram #(.AWIDTH(12), .IWIDTH(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (bus),
    .o_we    (o_we),
    .o_waddr (o_waddr),
    .o_wdata (o_wdata),
    .o_raddr (o_raddr),
    .i_rdata (i_rdata)
  );

  typedef struct { logic [11:0] addr; logic [31:0] data; } wexp_t;
  typedef struct { logic [4:0] id; logic [1:0] resp; } bexp_t;
  typedef struct { logic [31:0] data; logic last; logic [4:0] id; logic [1:0] resp; } rexp_t;

  wexp_t w_q[$];
  bexp_t b_q[$];
  rexp_t r_q[$];
  wexp_t wm;
  bexp_t bm;
  rexp_t rm;

  logic [31:0] sram    [4096];
  logic [31:0] ref_mem [4096];

  int n_vec = 0, n_err = 0, cyc = 0;
  int r_first = -1, r_last = -1;
  int b_cyc, ar_cyc;
  logic ar_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // External SRAM: registered read, one-cycle latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_we) sram[o_waddr] <= o_wdata;
    i_rdata <= sram[o_raddr];
  end

  always @(negedge clk) begin
    if (o_we) begin
      if (w_q.size() == 0) check("unexpected_we", 1, 0);
      else begin
        wm = w_q.pop_front();
        check("waddr", o_waddr, wm.addr);
        check("wdata", o_wdata, wm.data);
      end
    end
    if (bus.bvalid && bus.bready) begin
      if (b_q.size() == 0) check("unexpected_b", 1, 0);
      else begin
        bm = b_q.pop_front();
        check("bid", bus.bid, bm.id);
        check("bresp", bus.bresp, bm.resp);
      end
    end
    if (bus.rvalid) begin
      if (r_q.size() == 0) check("unexpected_r", 1, 0);
      else begin
        rm = r_q[0];
        check("rdata", bus.rdata, rm.data);
        check("rlast", bus.rlast, rm.last);
        check("rid", bus.rid, rm.id);
        check("rresp", bus.rresp, rm.resp);
        if (bus.rready) begin
          void'(r_q.pop_front());
          if (r_first < 0) r_first = cyc;
          r_last = cyc;
        end
      end
    end
  end

  task automatic write_burst(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [31:0] base, input int n_send,
                             output int bc, output logic ar_seen);
    logic ok;
    logic [11:0] a;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len;
    bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b1;
    ok = 1'b0; ar_seen = 1'b0; bc = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk); ok = bus.awready; ar_seen = bus.arready;
      @(posedge clk); #1;
    end
    bus.awvalid = 1'b0;
    if (!ok) check("aw_timeout", 0, 1);
    if (n_send == int'(len) + 1) b_q.push_back('{id: id, resp: 2'b00});
    a = addr[13:2];
    for (int i = 0; i < n_send; i++) begin
      w_q.push_back('{addr: a, data: base + i});
      ref_mem[a] = base + i;
      bus.wdata = base + i; bus.wstrb = 4'hF; bus.wlast = (i == int'(len)); bus.wvalid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clk); ok = bus.wready;
        @(posedge clk); #1;
      end
      if (!ok) check("w_timeout", 0, 1);
      a = a + 12'd1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    if (n_send == int'(len) + 1) begin
      bus.bready = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clk); ok = bus.bvalid;
        @(posedge clk); #1;
      end
      if (!ok) check("b_timeout", 0, 1);
      bc = cyc;
      bus.bready = 1'b0;
    end
  endtask

  task automatic read_burst(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic toggle, output int ac);
    logic ok;
    logic [11:0] a;
    a = addr[13:2];
    for (int i = 0; i <= int'(len); i++) begin
      r_q.push_back('{data: ref_mem[a], last: (i == int'(len)), id: id, resp: 2'b00});
      a = a + 12'd1;
    end
    r_first = -1;
    bus.arid = id; bus.araddr = addr; bus.arlen = len;
    bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk); ok = bus.arready;
      @(posedge clk); #1;
    end
    ac = cyc;
    bus.arvalid = 1'b0;
    if (!ok) check("ar_timeout", 0, 1);
    bus.rready = !toggle;
    for (int t = 0; t < 600 && r_q.size() != 0; t++) begin
      @(posedge clk); #1;
      if (toggle) bus.rready = ~bus.rready;
    end
    if (r_q.size() != 0) check("r_timeout", r_q.size(), 0);
    bus.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin sram[i] = 32'd0; ref_mem[i] = 32'd0; end
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = 2'b01;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2;
    bus.arburst = 2'b01; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", bus.awready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_wready",  bus.wready, 0);
    check("rst_bvalid",  bus.bvalid, 0);
    check("rst_rvalid",  bus.rvalid, 0);
    check("rst_rlast",   bus.rlast, 0);
    check("rst_bresp",   bus.bresp, 0);
    check("rst_rresp",   bus.rresp, 0);
    check("rst_we",      o_we, 0);
    check("rst_raddr",   o_raddr, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 8-beat write then back-to-back read of the same words
    write_burst(5'h0A, 32'h0, 8'd7, 32'h100, 8, b_cyc, ar_rdy);
    read_burst(5'h03, 32'h0, 8'd7, 1'b0, ar_cyc);
    check("r_back_to_back", r_last - r_first, 7);

    // Read with rready toggling
    read_burst(5'h11, 32'h0, 8'd7, 1'b1, ar_cyc);

    // Simultaneous AW and AR: write first, read the cycle after B
    bus.arid = 5'h15; bus.araddr = 32'h10; bus.arlen = 8'd3; bus.arvalid = 1'b1;
    write_burst(5'h07, 32'h20, 8'd3, 32'hA5A5_0000, 4, b_cyc, ar_rdy);
    check("tie_arready", ar_rdy, 0);
    read_burst(5'h15, 32'h10, 8'd3, 1'b0, ar_cyc);
    check("ar_after_b", ar_cyc, b_cyc + 1);

    // Address wrap 4094,4095,0,1
    write_burst(5'h1F, 32'h3FF8, 8'd3, 32'hBEEF_0000, 4, b_cyc, ar_rdy);
    check("wrap_word0", ref_mem[0], 32'hBEEF_0002);
    read_burst(5'h04, 32'h3FF8, 8'd3, 1'b0, ar_cyc);

    // Reset during beat 3 of an 8-beat write
    write_burst(5'h02, 32'h80, 8'd7, 32'hC000_0000, 3, b_cyc, ar_rdy);
    bus.wdata = 32'hC000_0003; bus.wvalid = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    check("abort_we", o_we, 0);
    @(posedge clk); #1 bus.wvalid = 1'b0;
    @(negedge clk);
    check("abort_awready", bus.awready, 0);
    check("abort_arready", bus.arready, 0);
    check("abort_wready",  bus.wready, 0);
    check("abort_bvalid",  bus.bvalid, 0);
    check("abort_rvalid",  bus.rvalid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    write_burst(5'h09, 32'h80, 8'd3, 32'hD000_0000, 4, b_cyc, ar_rdy);
    read_burst(5'h0C, 32'h80, 8'd7, 1'b0, ar_cyc);

    repeat (4) @(posedge clk);
    check("w_q_drained", w_q.size(), 0);
    check("b_q_drained", b_q.size(), 0);
    check("r_q_drained", r_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
